// File: rtl/i2s_sample_streamer.sv
// i2s_sample_streamer: FIFO-buffered PCM samples serialized MSB-first onto the I2S DAC line, each sample played on both channels
module i2s_sample_streamer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LEVEL_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    bclk,
  input  logic                    lrck,
  output logic                    aud_dacdat,
  output logic [LEVEL_WIDTH-1:0]  fifo_level,
  output logic                    underrun,
  output logic [15:0]             underrun_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [LEVEL_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [2:0] bclk_sync, lrck_sync;
  logic bclk_fall, lr_fall, lr_rise, empty, push, pop, shifting;
  logic [SAMPLE_WIDTH-1:0] hold, shreg, hold_nx, shreg_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic dac, dac_nx, underrun_nx;
  logic [15:0] underrun_count_nx;
  always_ff @(posedge clk) begin
    bclk_sync <= rst ? 3'b000 : {bclk_sync[1:0], bclk};
    lrck_sync <= rst ? 3'b000 : {lrck_sync[1:0], lrck};
  end
  // bit [1] is the synchronized level, bit [2] its previous value
  assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
  assign lr_fall = lrck_sync[2] & ~lrck_sync[1];
  assign lr_rise = ~lrck_sync[2] & lrck_sync[1];
  assign fifo_level = wr_ptr - rd_ptr;
  assign empty = fifo_level == '0;
  assign s_ready = fifo_level != LEVEL_WIDTH'(FIFO_DEPTH);
  assign push = s_valid && s_ready;
  assign pop = lr_fall && enable && !empty;
  assign shifting = cnt < CW'(SAMPLE_WIDTH);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + LEVEL_WIDTH'(push);
      rd_ptr <= rd_ptr + LEVEL_WIDTH'(pop);
    end
  end
  always_comb begin
    hold_nx = hold;
    shreg_nx = shreg;
    cnt_nx = cnt;
    dac_nx = dac;
    underrun_nx = 1'b0;
    underrun_count_nx = underrun_count;
    if (lr_fall) begin
      hold_nx = pop ? mem[rd_ptr[AW-1:0]] : '0;
      shreg_nx = hold_nx;
      cnt_nx = '0;
      dac_nx = 1'b0;
      underrun_nx = enable && empty;
      underrun_count_nx = (underrun_nx && ~&underrun_count) ? underrun_count + 16'd1 : underrun_count;
    end else if (lr_rise) begin
      shreg_nx = hold;
      cnt_nx = '0;
      dac_nx = 1'b0;
    end else if (bclk_fall) begin
      dac_nx = shifting && shreg[SAMPLE_WIDTH-1];
      shreg_nx = shifting ? shreg << 1 : shreg;
      cnt_nx = shifting ? cnt + 1'b1 : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      shreg <= '0;
      cnt <= CW'(SAMPLE_WIDTH);
      dac <= 1'b0;
      underrun <= 1'b0;
      underrun_count <= '0;
    end else begin
      hold <= hold_nx;
      shreg <= shreg_nx;
      cnt <= cnt_nx;
      dac <= dac_nx;
      underrun <= underrun_nx;
      underrun_count <= underrun_count_nx;
    end
  end
  assign aud_dacdat = dac & enable;
endmodule

// File: tb/tb_i2s_sample_streamer.sv
// tb_i2s_sample_streamer: random-traffic bench against a queue-based model of the I2S sample streamer
module tb_i2s_sample_streamer;
  localparam int SW = 16, DEPTH = 16, LW = 5, SLOT = 18;
  logic clk = 0, rst = 1, s_valid = 0, s_ready, enable = 0, flush = 0, bclk = 1, lrck = 1;
  logic aud_dacdat, underrun;
  logic [SW-1:0] s_data = '0;
  logic [LW-1:0] fifo_level;
  logic [15:0] underrun_count;
  int total = 0, bad = 0;
  logic [SW-1:0] q[$];
  logic [SW-1:0] word = '0;
  int ucnt = 0, mode;
  bit act, sv;
  always #5 clk = ~clk;
  i2s_sample_streamer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .enable(enable), .flush(flush), .bclk(bclk), .lrck(lrck), .aud_dacdat(aud_dacdat),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_count(underrun_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // one clk cycle; a_left marks the cycle whose edge carries the detected left-slot LRCK fall
  task automatic tick(input bit lr, input bit bc, input bit a_left, input bit v, input logic [SW-1:0] d);
    int pre;
    bit ur;
    @(negedge clk);
    lrck = lr;
    bclk = bc;
    s_valid = v;
    s_data = d;
    flush = ($urandom_range(0, 1499) == 0);
    @(posedge clk);
    #1;
    pre = q.size();
    ur = 0;
    if (rst) begin
      q.delete();
      ucnt = 0;
      word = '0;
      check("rst_dac", aud_dacdat, 0);
    end else begin
      if (a_left) begin
        ur = enable && pre == 0;
        word = (enable && pre != 0) ? q[0] : '0;
        if (enable && pre != 0) void'(q.pop_front());
        if (ur && ucnt != 16'hFFFF) ucnt++;
      end
      if (flush) q.delete();
      else if (v && pre < DEPTH) q.push_back(d);
    end
    check("level", fifo_level, q.size());
    check("ready", s_ready, q.size() < DEPTH);
    check("underrun", underrun, ur);
    check("ucount", underrun_count, ucnt);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, '0);
    rst = 0;
    for (int i = 0; i < 6; i++) tick(1, 1, 0, 0, '0);
    for (int f = 0; f < 40; f++) begin
      mode = f == 0 ? 3 : f == 1 ? 0 : int'($urandom_range(0, 3));
      enable = f < 2 ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < SLOT; b++)
          for (int t = 0; t < 8; t++) begin
            act = s == 0 && b == 0 && t == 2;
            sv = mode == 1 ? $urandom_range(0, 299) == 0 : mode == 2 ? $urandom_range(0, 3) == 0 : mode == 3 ? act : 1'b0;
            rst = f == 20 && s == 0 && b == 7 && t == 5;
            tick(s[0], t >= 4, act, sv, f == 0 ? 16'hA5C3 : SW'($urandom));
            if (t == 4) check("bit", aud_dacdat, (enable && b >= 1 && b <= SW) ? word[SW-b] : 1'b0);
          end
    end
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_sample_streamer.md
Name: i2s_sample_streamer

Overview:
- Replaces the fixed-ROM playback path in front of the audio codec with a streaming sample feed.
- Accepts PCM samples from an upstream producer (synthesizer, sample sequencer) over a valid/ready handshake and buffers them in an internal FIFO.
- Serializes samples MSB-first onto the codec DAC data line, aligned to the BCLK and LRCK produced by the codec clock dividers.
- Each sample is played on both channels (mono duplicate).

Parameters:
- SAMPLE_WIDTH, 16, bits per sample and bits shifted per channel slot.
- FIFO_DEPTH, 16, FIFO entries; must be a power of two, 2 or more.
- LEVEL_WIDTH, 5, width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- s_data  input  SAMPLE_WIDTH  sample, two's complement.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  FIFO can accept a sample.
- enable  input  1  playback enable.
- flush  input  1  synchronous FIFO clear.
- bclk  input  1  codec bit clock (from divider, asynchronous to clk).
- lrck  input  1  codec channel clock; 0 = left, 1 = right.
- aud_dacdat  output  1  serial DAC data.
- fifo_level  output  LEVEL_WIDTH  entries currently stored.
- underrun  output  1  one-cycle pulse when a slot started with the FIFO empty.
- underrun_count  output  16  saturating count of underrun events.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: FIFO empty, fifo_level=0, s_ready=1, aud_dacdat=0, underrun=0, underrun_count=0, shift register=0, bit counter=SAMPLE_WIDTH (idle). Synchronizer flops reset to 0.
- Reset mid-stream: discards FIFO contents and the sample currently being shifted. aud_dacdat=0 on the next cycle.
- Input sync: bclk and lrck each pass through a 2-flop synchronizer plus an edge-detect flop. Detected edges lag the pin edge by 3 clk cycles.
- FIFO handshake:
  - s_ready = !full.
  - A push occurs when s_valid && s_ready.
  - fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.
  - A pop decision uses the pre-cycle state. An empty FIFO with a same-cycle push still counts as an underrun, and the pushed word stays in the FIFO.
- flush:
  - Empties the FIFO on the next cycle; it has priority over a same-cycle push.
  - Does not stop a sample already in the shift register.
  - Does not change underrun_count.
- Per-channel state machine: IDLE → SHIFT → IDLE. The state is the bit counter: SHIFT while counter < SAMPLE_WIDTH.
- LRCK falling edge (start of left slot):
  - If enable && !empty: pop the head into the hold register and the shift register.
  - If enable && empty: load 0 into both, pulse underrun for 1 cycle, and increment underrun_count, saturating at 0xFFFF.
  - If !enable: load 0 into both; no pop, no underrun.
  - In all cases: counter=0, aud_dacdat=0.
- LRCK rising edge (start of right slot): reload the shift register from the hold register (replay). No pop; counter=0; aud_dacdat=0.
- BCLK falling edge with counter < SAMPLE_WIDTH:
  - aud_dacdat = shift register MSB, shift left, counter+1.
  - The first falling edge after the channel edge outputs the MSB, giving the 1-BCLK I2S delay.
- BCLK falling edge with counter = SAMPLE_WIDTH: aud_dacdat=0. This covers slots longer than SAMPLE_WIDTH bits.
- Simultaneous LRCK edge and BCLK falling edge in the same clk cycle: the LRCK action wins and that BCLK edge is not counted.
- enable low: aud_dacdat is forced to 0 combinationally, on top of the gating at the slot boundary.
- Output timing: aud_dacdat is registered and changes only on cycles with a detected edge, at a 3-cycle lag from the BCLK pin edge.

Test Plan:
- Reset, then push 0xA5C3 with enable=1, then one left slot → aud_dacdat emits 1010010111000011 on successive BCLK falls, then 0. The right slot repeats the same 16 bits. fifo_level goes 1→0 at the left edge.
- Push 16 words with s_valid held high → s_ready drops after the 16th push and fifo_level=16. A 17th word is not accepted until a pop, then lands as entry 16.
- FIFO empty at a left edge, enable=1 → underrun high for exactly 1 cycle, underrun_count=1, and all 32 slot bits are 0.
- Push on the same cycle as a left edge with the FIFO empty → underrun fires, fifo_level=1 afterwards, and the word plays in the next frame.
- LRCK and BCLK edges detected in the same cycle → the shift register reloads, the counter is 0, and the MSB appears on the following BCLK fall.
- Assert rst mid-slot (after 7 bits) → next cycle aud_dacdat=0, fifo_level=0, underrun_count=0, s_ready=1. flush with 5 entries gives fifo_level=0 with the count kept.
